// File: rtl/if_id_stage_if.sv
// if_id_stage_if: groups the fetch-side inputs, hazard/flush controls and
// all IF/ID outputs of the IF/ID pipeline register into one bundle.
//   slave  modport : used by if_id_stage (consumes i_*, drives o_* / dbg_state)
//   master modport : used by the surrounding pipeline or a bench
// Signal summary:
//   i_instruction, i_pc_increment : fetch output (instruction, PC+4)
//   i_flush                       : taken branch or jump this cycle
//   i_id_ex_mem_read, i_id_ex_rt  : load currently in ID/EX and its rt
//   o_instruction .. o_jump_target: latched instruction and pre-split fields
//   o_stall, o_bubble             : hold fetch/IF-ID, zero ID/EX controls
//   o_stall_count, o_flush_count  : saturating event counters
//   dbg_state                     : stall FSM state (0 = RUN, 1 = STALL)
// Flow-control semantics: there is no valid/ready pair here. o_valid marks
// the latched instruction as live; o_stall plays the role of "not ready"
// toward fetch and is combinational in the same cycle as the hazard; a
// flush always wins over a stall and kills the latched instruction.
interface if_id_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] i_instruction;
  logic [DATA_W-1:0] i_pc_increment;
  logic              i_flush;
  logic              i_id_ex_mem_read;
  logic [4:0]        i_id_ex_rt;

  logic [DATA_W-1:0] o_instruction;
  logic [DATA_W-1:0] o_pc_increment;
  logic              o_valid;
  logic [5:0]        o_opcode;
  logic [4:0]        o_rs;
  logic [4:0]        o_rt;
  logic [4:0]        o_rd;
  logic [4:0]        o_shamt;
  logic [5:0]        o_funct;
  logic [DATA_W-1:0] o_imm_sext;
  logic [DATA_W-1:0] o_jump_target;
  logic              o_stall;
  logic              o_bubble;
  logic [CNT_W-1:0]  o_stall_count;
  logic [CNT_W-1:0]  o_flush_count;
  logic              dbg_state;

  modport slave (
    input  i_instruction, i_pc_increment, i_flush, i_id_ex_mem_read, i_id_ex_rt,
    output o_instruction, o_pc_increment, o_valid, o_opcode, o_rs, o_rt, o_rd,
           o_shamt, o_funct, o_imm_sext, o_jump_target, o_stall, o_bubble,
           o_stall_count, o_flush_count, dbg_state
  );

  modport master (
    output i_instruction, i_pc_increment, i_flush, i_id_ex_mem_read, i_id_ex_rt,
    input  o_instruction, o_pc_increment, o_valid, o_opcode, o_rs, o_rt, o_rd,
           o_shamt, o_funct, o_imm_sext, o_jump_target, o_stall, o_bubble,
           o_stall_count, o_flush_count, dbg_state
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register of the five-stage MIPS core.
// Captures instruction and PC+4 from fetch, detects load-use hazards
// against the load in ID/EX, flushes on taken branches/jumps, and presents
// pre-split decode fields to ID.
// Ports:
//   i_clk   : rising-edge clock
//   i_reset : asynchronous active-low reset
//   bus     : if_id_stage_if.slave (see interface file for signal list)
module if_id_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic          i_clk,
  input logic          i_reset,
  if_id_stage_if.slave bus
);

  // Stall FSM is implicit: STALL exactly when the hazard is live and no
  // flush is present. The enum only names that state for observation.
  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] pcinc_q;
  logic              valid_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic [4:0] rs_q;
  logic [4:0] rt_q;
  logic       hazard;
  logic       stall;
  state_e     state;

  assign rs_q = instr_q[25:21];
  assign rt_q = instr_q[20:16];

  // rt is compared for every format on purpose: cheaper than decoding which
  // formats actually read rt, at the cost of an occasional needless stall.
  always_comb begin
    hazard = 1'b0;
    stall  = 1'b0;
    state  = ST_RUN;
    hazard = valid_q & bus.i_id_ex_mem_read & (bus.i_id_ex_rt != 5'd0) &
             ((bus.i_id_ex_rt == rs_q) | (bus.i_id_ex_rt == rt_q));
    // A flush discards the dependent instruction, so it needs no stall.
    stall  = hazard & ~bus.i_flush;
    state  = stall ? ST_STALL : ST_RUN;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      instr_q     <= '0;
      pcinc_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.i_flush) begin
        instr_q <= '0;
        pcinc_q <= bus.i_pc_increment;
        valid_q <= 1'b0;
      end else if (!stall) begin
        instr_q <= bus.i_instruction;
        pcinc_q <= bus.i_pc_increment;
        valid_q <= 1'b1;
      end
      // Counters saturate at all-ones so long runs never alias to small values.
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.i_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // instr_q is forced to zero whenever valid_q is low, so every field below
  // reads as sll $0,$0,0 for a dead slot without extra gating.
  assign bus.o_instruction  = instr_q;
  assign bus.o_pc_increment = pcinc_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_opcode       = instr_q[31:26];
  assign bus.o_rs           = instr_q[25:21];
  assign bus.o_rt           = instr_q[20:16];
  assign bus.o_rd           = instr_q[15:11];
  assign bus.o_shamt        = instr_q[10:6];
  assign bus.o_funct        = instr_q[5:0];
  assign bus.o_imm_sext     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign bus.o_jump_target  = {pcinc_q[31:28], instr_q[25:0], 2'b00};
  assign bus.o_stall        = stall;
  assign bus.o_bubble       = stall;
  assign bus.o_stall_count  = stall_cnt_q;
  assign bus.o_flush_count  = flush_cnt_q;
  assign bus.dbg_state      = state;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  if_id_stage_if #(.DATA_W(32), .CNT_W(CNT_W)) bus ();

  if_id_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  logic [31:0] exp_q[$];

  // Reference model: architectural state of the stage.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_sc;
  int          m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_sc    = 0;
    m_fc    = 0;
  endtask

  // Load-use rule: a live instruction reading the non-zero rt of a load in
  // ID/EX must wait, unless it is being flushed anyway.
  function automatic logic model_stall();
    int rs_f;
    int rt_f;
    int ld;
    rs_f = int'((m_instr >> 21) & 32'h1F);
    rt_f = int'((m_instr >> 16) & 32'h1F);
    ld   = int'(bus.i_id_ex_rt);
    return m_valid && bus.i_id_ex_mem_read && (ld != 0) &&
           ((ld == rs_f) || (ld == rt_f)) && !bus.i_flush;
  endfunction

  task automatic set_in(input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic mr, input logic [4:0] rt);
    bus.i_instruction    = instr;
    bus.i_pc_increment   = pc;
    bus.i_flush          = fl;
    bus.i_id_ex_mem_read = mr;
    bus.i_id_ex_rt       = rt;
  endtask

  // One clock: predict from pre-edge inputs, commit after the edge.
  task automatic tick();
    logic        st;
    logic        fl;
    logic [31:0] n_instr;
    logic [31:0] n_pc;
    logic        n_valid;
    st = model_stall();
    fl = bus.i_flush;
    n_instr = m_instr;
    n_pc    = m_pc;
    n_valid = m_valid;
    if (fl) begin
      n_instr = 32'h0;
      n_pc    = bus.i_pc_increment;
      n_valid = 1'b0;
    end else if (!st) begin
      n_instr = bus.i_instruction;
      n_pc    = bus.i_pc_increment;
      n_valid = 1'b1;
    end
    @(posedge clk);
    if (rst_n) begin
      m_instr = n_instr;
      m_pc    = n_pc;
      m_valid = n_valid;
      if (st && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
    end
    exp_q.push_back(m_instr);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_imm;
    logic [31:0] e_jt;
    logic        e_st;
    e_imm = m_instr & 32'hFFFF;
    if (e_imm >= 32'h8000) e_imm = e_imm + 32'hFFFF_0000;
    e_jt = (m_pc & 32'hF000_0000) + ((m_instr & 32'h03FF_FFFF) * 4);
    e_st = model_stall();
    check({tag, ".instr"},  bus.o_instruction, m_instr);
    check({tag, ".pc"},     bus.o_pc_increment, m_pc);
    check({tag, ".valid"},  32'(bus.o_valid), 32'(m_valid));
    check({tag, ".opcode"}, 32'(bus.o_opcode), m_instr >> 26);
    check({tag, ".rs"},     32'(bus.o_rs), (m_instr >> 21) & 32'h1F);
    check({tag, ".rt"},     32'(bus.o_rt), (m_instr >> 16) & 32'h1F);
    check({tag, ".rd"},     32'(bus.o_rd), (m_instr >> 11) & 32'h1F);
    check({tag, ".shamt"},  32'(bus.o_shamt), (m_instr >> 6) & 32'h1F);
    check({tag, ".funct"},  32'(bus.o_funct), m_instr & 32'h3F);
    check({tag, ".imm"},    bus.o_imm_sext, e_imm);
    check({tag, ".jt"},     bus.o_jump_target, e_jt);
    check({tag, ".stall"},  32'(bus.o_stall), 32'(e_st));
    check({tag, ".bubble"}, 32'(bus.o_bubble), 32'(e_st));
    check({tag, ".scnt"},   32'(bus.o_stall_count), 32'(m_sc));
    check({tag, ".fcnt"},   32'(bus.o_flush_count), 32'(m_fc));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fl;
    logic        mr;
    logic [4:0]  rt;
    logic        exp_stall;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[7];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    model_reset();

    vecs[0] = '{32'h8C22_0004, 32'h0000_0008, 1'b0, 1'b0, 5'd0, 1'b0, 32'h8C22_0004, 32'h0000_0008, 1'b1};
    vecs[1] = '{32'h0022_1820, 32'h0000_000C, 1'b0, 1'b0, 5'd2, 1'b0, 32'h0022_1820, 32'h0000_000C, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0022_1820, 32'h0000_000C, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b1, 5'd0, 1'b0, 32'h1234_5678, 32'h0000_0010, 1'b1};
    vecs[4] = '{32'h2021_FFFC, 32'h0000_0014, 1'b0, 1'b1, 5'd5, 1'b0, 32'h2021_FFFC, 32'h0000_0014, 1'b1};
    vecs[5] = '{32'hABCD_0000, 32'h0000_0018, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0000_0000, 32'h0000_0018, 1'b0};
    vecs[6] = '{32'h8C22_0004, 32'h0000_001C, 1'b0, 1'b1, 5'd1, 1'b0, 32'h8C22_0004, 32'h0000_001C, 1'b1};

    // Reset state
    @(posedge clk);
    #1;
    tick();
    check_all("reset");
    check("reset.state", 32'(bus.dbg_state), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].instr, vecs[i].pc, vecs[i].fl, vecs[i].mr, vecs[i].rt);
      #1;
      check($sformatf("vec%0d.stall", i), 32'(bus.o_stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d.bubble", i), 32'(bus.o_bubble), 32'(vecs[i].exp_stall));
      tick();
      check($sformatf("vec%0d.instr", i), bus.o_instruction, vecs[i].exp_instr);
      check($sformatf("vec%0d.pc", i), bus.o_pc_increment, vecs[i].exp_pc);
      check($sformatf("vec%0d.valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
    end
    check("table.scnt", 32'(bus.o_stall_count), 32'h1);
    check("table.fcnt", 32'(bus.o_flush_count), 32'h1);

    // Reset mid-stall: state and stall clear before the next edge
    set_in(32'h0000_0000, 32'h0000_0020, 1'b0, 1'b1, 5'd2);
    #1;
    check("midrst.pre_stall", 32'(bus.o_stall), 32'h1);
    check("midrst.pre_state", 32'(bus.dbg_state), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst.async");
    tick();
    rst_n = 1'b1;

    // First load after reset, then sign extension and jump target
    set_in(32'h8C22_0004, 32'h0000_0008, 1'b0, 1'b0, 5'd0);
    tick();
    check("ld.valid", 32'(bus.o_valid), 32'h1);
    check("ld.opcode", 32'(bus.o_opcode), 32'h23);
    check("ld.rs", 32'(bus.o_rs), 32'h1);
    check("ld.rt", 32'(bus.o_rt), 32'h2);
    check("ld.imm", bus.o_imm_sext, 32'h0000_0004);
    set_in(32'h2021_FFFC, 32'hA000_0010, 1'b0, 1'b0, 5'd0);
    tick();
    check("sext.imm", bus.o_imm_sext, 32'hFFFF_FFFC);
    set_in(32'h0810_0000, 32'hA000_0014, 1'b0, 1'b0, 5'd0);
    tick();
    check("jmp.target", bus.o_jump_target, 32'hA040_0000);
    check_all("jmp");

    // Randomized phase against the model
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] lo;
      logic [31:0] pc;
      logic        fl;
      logic        mr;
      logic [4:0]  lrt;
      logic [31:0] got;
      op  = 6'($urandom_range(0, 63));
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      lo  = 16'($urandom);
      pc  = $urandom;
      fl  = ($urandom_range(0, 7) == 0);
      mr  = ($urandom_range(0, 1) == 1);
      lrt = 5'($urandom_range(0, 3));
      set_in({op, rs, rt, lo}, pc, fl, mr, lrt);
      #1;
      check("rand.stall", 32'(bus.o_stall), 32'(model_stall()));
      tick();
      got = exp_q.pop_front();
      check("rand.instr", bus.o_instruction, got);
      check_all("rand");
    end

    // Stall counter saturation
    apply_reset();
    set_in(32'h0022_1820, 32'h0000_0004, 1'b0, 1'b0, 5'd0);
    tick();
    set_in(32'h1111_1111, 32'h0000_0008, 1'b0, 1'b1, 5'd2);
    for (int k = 0; k < (1 << CNT_W) + 3; k++) tick();
    check("sat.scnt", 32'(bus.o_stall_count), 32'(CMAX));
    check("sat.stall", 32'(bus.o_stall), 32'h1);
    check("sat.hold", bus.o_instruction, 32'h0022_1820);
    check_all("sat");

    // Flush counter saturation, flush beats a live hazard
    set_in(32'h1111_1111, 32'h0000_0008, 1'b1, 1'b1, 5'd2);
    #1;
    check("flvs.stall", 32'(bus.o_stall), 32'h0);
    for (int k = 0; k < (1 << CNT_W) + 3; k++) tick();
    check("fsat.fcnt", 32'(bus.o_flush_count), 32'(CMAX));
    check("fsat.valid", 32'(bus.o_valid), 32'h0);
    check_all("fsat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline stage of the five-stage MIPS core. It sits directly downstream of instruction fetch and captures the fetched instruction and PC+4 each cycle. It detects load-use hazards against the instruction in ID/EX and handles flushes on taken branches and jumps. It presents pre-split decode fields to the ID stage and drives the stall/bubble controls back to fetch and to ID/EX.

## Interface
Parameters:
- DATA_W, 32, instruction/PC width (fixed at 32 for MIPS; not to be overridden)
- CNT_W, 16, width of the saturating stall and flush event counters

Ports:
- i_clk  in  1  clock, rising-edge
- i_reset  in  1  asynchronous, active-low reset; single clock domain
- i_instruction  in  32  instruction from fetch (o_instruction of fetch)
- i_pc_increment  in  32  PC+4 from fetch
- i_flush  in  1  taken branch (branch AND zero) or jump this cycle
- i_id_ex_mem_read  in  1  instruction currently in ID/EX is a load
- i_id_ex_rt  in  5  destination rt of that load
- o_instruction  out  32  latched instruction (NOP = 32'h0000_0000 when invalid)
- o_pc_increment  out  32  latched PC+4
- o_valid  out  1  latched instruction is live
- o_opcode  out  6  o_instruction[31:26]
- o_rs, o_rt, o_rd  out  5 each  [25:21], [20:16], [15:11]
- o_shamt  out  5  [10:6]
- o_funct  out  6  [5:0]
- o_imm_sext  out  32  sign-extended [15:0]
- o_jump_target  out  32  {o_pc_increment[31:28], o_instruction[25:0], 2'b00}
- o_stall  out  1  hold PC and this register (to fetch PC write-enable, inverted)
- o_bubble  out  1  force control signals to zero into ID/EX
- o_stall_count, o_flush_count  out  CNT_W  event counters

## Operation
- Register state: instr_q, pcinc_q, valid_q, stall_cnt_q, flush_cnt_q.
- Hazard (combinational from state plus inputs): hazard = valid_q & i_id_ex_mem_read & (i_id_ex_rt != 0) & ((i_id_ex_rt == rs_q) | (i_id_ex_rt == rt_q)). The rt comparison is deliberately conservative; it is made for all formats.
- o_stall = hazard & ~i_flush; o_bubble = o_stall.
- Per rising edge, highest priority first:
  1. i_flush: instr_q←0, pcinc_q←i_pc_increment, valid_q←0. Flush overrides a concurrent stall.
  2. o_stall: all registers hold.
  3. Otherwise: instr_q←i_instruction, pcinc_q←i_pc_increment, valid_q←1.
- Decode fields derive combinationally from instr_q. When valid_q=0, instr_q=0, so all fields are zero (sll $0,$0,0).
- Counters: stall_cnt increments on each cycle with o_stall=1. flush_cnt increments on each cycle with i_flush=1. Both saturate at all-ones and never wrap.
- Stall state machine, implicit in valid_q/hazard:
  - RUN → STALL when hazard.
  - STALL lasts exactly one cycle, because ID/EX receives a bubble and its mem_read drops → RUN.
  - Back-to-back stalls are permitted if upstream re-asserts mem_read; the block does not limit them.

## Timing
- Latency: one cycle from fetch output to o_instruction.
- Reset (i_reset=0, asynchronous): instr_q=0, pcinc_q=0, valid_q=0, both counters 0. Therefore o_stall=0, o_bubble=0, and all decode fields are 0.
- Reset deassertion is synchronous to i_clk at the integrating level. The first edge after deassertion loads fetch output.
- Reset mid-stall: state clears immediately and the stall drops combinationally.
- o_stall and o_bubble are combinational in the same cycle as the hazard. There is no registered path from i_id_ex_* to o_stall.
- i_flush and a load-use hazard in the same cycle: o_stall=0 and the register is flushed. The dependent instruction is discarded, so no stall is needed.
- A $0 destination never stalls.

## Test plan
- Reset: assert i_reset=0 mid-run with valid_q=1 → all outputs 0 asynchronously before the next edge. Release reset, drive instr 32'h8C22_0004 with pc+4 32'h0000_0008 → next edge: o_valid=1, o_opcode=6'h23, o_rs=1, o_rt=2, o_imm_sext=32'h4.
- Sign extension and jump target: instr 32'h2021_FFFC, pc+4 32'hA000_0010 → o_imm_sext=32'hFFFF_FFFC. Then instr 32'h0810_0000 → o_jump_target=32'hA040_0000.
- Load-use: o_instruction=32'h0022_1820 (add $3,$1,$2), i_id_ex_mem_read=1, i_id_ex_rt=2 → o_stall=o_bubble=1. Register holds over the edge and stall_count=1. Drop mem_read → loads the next instruction.
- No false stall: i_id_ex_rt=0 with mem_read=1, or i_id_ex_rt=5 unrelated → o_stall=0.
- Flush vs stall: hazard active and i_flush=1 in the same cycle → o_stall=0. After the edge: o_valid=0, o_instruction=0, flush_count increments.
- Saturation: hold a hazard for 2^CNT_W+3 cycles (use CNT_W=4 in a test build) → o_stall_count stays 4'hF with no wrap.
